mem_bus_arb: RTL

//  Shares one word-wide memory port between the fetch (I) and data (D) sides
//  of the core. Runs a req/ack handshake with a variable-latency memory.

---
 rtl/mem_bus_arb.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arb.sv
// Arbitrates the core's fetch and data ports onto one req/ack memory port,
// with byte-lane steering for stores and sign/zero extension for loads.
module mem_bus_arb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic [31:0]       m_rdata,
  input  logic              m_ack,
  output logic              stall
);
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              own_d_q, own_d_d;     // 1: data side owns the transaction
  logic              prio_d_q, prio_d_d;   // 1: data side wins a tie
  logic              bad_q, bad_d;         // misaligned, memory never touched
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        alo_q, alo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              gnt_d, gnt_i, d_mis, i_mis, resp;
  logic [3:0]        d_strb;
  logic [31:0]       d_wlanes, lane, load_ext;

  always_comb begin
    d_mis = (d_size[1:0] == 2'b01 && d_addr[0]) || (d_size[1] && d_addr[1:0] != 2'b00);
    i_mis = if_addr[1:0] != 2'b00;
    case (d_size[1:0])
      2'b00: begin
        d_strb   = 4'b0001 << d_addr[1:0];
        d_wlanes = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_strb   = 4'b0011 << d_addr[1:0];
        d_wlanes = {2{d_wdata[15:0]}};
      end
      default: begin
        d_strb   = 4'b1111;
        d_wlanes = d_wdata;
      end
    endcase
  end

  always_comb begin
    lane = m_rdata >> {alo_q, 3'b000};
    case (size_q[1:0])
      2'b00:   load_ext = {{24{~size_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{~size_q[2] & lane[15]}}, lane[15:0]};
      default: load_ext = m_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    own_d_d   = own_d_q;
    prio_d_d  = prio_d_q;
    bad_d     = bad_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    size_d    = size_q;
    alo_d     = alo_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_d     = d_req & (~if_req | prio_d_q);
    gnt_i     = if_req & ~gnt_d;

    case (state_q)
      ST_IDLE: begin
        if (gnt_d || gnt_i) begin
          state_d = ST_BUSY;
          own_d_d = gnt_d;
          cnt_d   = '0;
          if (d_req && if_req) prio_d_d = ~gnt_d;
          if (gnt_d) begin
            m_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
            m_we_d    = d_we;
            m_wdata_d = d_wlanes;
            m_wstrb_d = d_we ? d_strb : 4'b0000;
            size_d    = d_size;
            alo_d     = d_addr[1:0];
            bad_d     = d_mis;
          end else begin
            m_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
            m_we_d    = 1'b0;
            m_wdata_d = '0;
            m_wstrb_d = 4'b0000;
            size_d    = 3'b010;
            alo_d     = 2'b00;
            bad_d     = i_mis;
          end
          m_req_d = ~bad_d;
        end
      end
      ST_BUSY: begin
        // Misaligned requests pass one cycle here with m_req low, so every
        // response arrives two cycles after the request at the earliest.
        if (bad_q) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (m_ack) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          err_d   = 1'b0;
          if (!own_d_q)   rdata_d = m_rdata;
          else if (m_we_q) rdata_d = '0;
          else             rdata_d = load_ext;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        bad_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      own_d_q   <= 1'b0;
      prio_d_q  <= 1'b1;
      bad_q     <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      size_q    <= '0;
      alo_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_d_q   <= own_d_d;
      prio_d_q  <= prio_d_d;
      bad_q     <= bad_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      size_q    <= size_d;
      alo_q     <= alo_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign resp     = state_q == ST_RESP;
  assign if_ack   = resp & ~own_d_q;
  assign d_ack    = resp & own_d_q;
  assign if_rdata = if_ack ? rdata_q : '0;
  assign d_rdata  = d_ack ? rdata_q : '0;
  assign if_err   = if_ack & err_q;
  assign d_err    = d_ack & err_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wstrb  = m_wstrb_q;
  assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);

  // A requester must hold its request until it has been acknowledged.
  a_if_hold: assert property (@(posedge clk) disable iff (!rst) (if_req && !if_ack) |=> if_req);
  a_d_hold:  assert property (@(posedge clk) disable iff (!rst) (d_req && !d_ack) |=> d_req);
endmodule
